// File: rtl/frost32_mem_access_unit_pkg.sv
// Shared types for the Frost32 load/store unit.
//   mem_access_unit_state_e  : FSM states of the load/store unit
//   data_inout_access_type_e : read/write request type
//   data_inout_access_size_e : log2(bytes) access-size encoding
//   access_bits()            : access width in bits for a size code
package frost32_mem_access_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } mem_access_unit_state_e;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } data_inout_access_type_e;

  typedef enum logic [1:0] {
    Dias8  = 2'd0,
    Dias16 = 2'd1,
    Dias32 = 2'd2,
    Dias64 = 2'd3
  } data_inout_access_size_e;

  // Width in bits of an access of the given log2-bytes size (8..64).
  function automatic logic [7:0] access_bits(input logic [1:0] size);
    return 8'd8 << size;
  endfunction

endpackage

// File: rtl/frost32_mem_access_unit_if.sv
// CPU-side request/response and memory-side bus of the load/store unit.
//   slave  : the load/store unit's view (takes CPU requests, drives memory)
//   master : the environment's view (issues CPU requests, acts as memory)
interface frost32_mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic                    cpu_req_type;
  logic [1:0]              cpu_req_size;
  logic                    cpu_req_sign_ext;
  logic [ADDR_WIDTH-1:0]   cpu_req_addr;
  logic [DATA_WIDTH-1:0]   cpu_req_wdata;
  logic                    cpu_resp_valid;
  logic [DATA_WIDTH-1:0]   cpu_resp_rdata;
  logic                    cpu_resp_err;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_byte_en;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_wait;

  modport slave (
    input  cpu_req_valid, cpu_req_type, cpu_req_size, cpu_req_sign_ext,
           cpu_req_addr, cpu_req_wdata, mem_rdata, mem_wait,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
           mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata
  );

  modport master (
    output cpu_req_valid, cpu_req_type, cpu_req_size, cpu_req_sign_ext,
           cpu_req_addr, cpu_req_wdata, mem_rdata, mem_wait,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
           mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata
  );
endinterface

// File: rtl/frost32_lane_extract.sv
// Combinational load-lane extraction: shift the addressed byte lane down,
// truncate to the access size, then sign- or zero-extend to DATA_WIDTH.
// Also used by writeback for forwarding.
//   data_i     : full bus word
//   lane_i     : byte lane of the access within the word
//   size_i     : log2(bytes) of the access
//   sign_ext_i : 1 = sign-extend, 0 = zero-extend
//   data_o     : extended result
module frost32_lane_extract
  import frost32_mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           data_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] lane_i,
  input  logic [1:0]                      size_i,
  input  logic                            sign_ext_i,
  output logic [DATA_WIDTH-1:0]           data_o
);
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [DATA_WIDTH-1:0] msb_mask;
  logic                  sign_bit;

  always_comb begin
    shifted   = data_i >> {lane_i, 3'b000};
    // Shifting by the full width yields 0, so a full-width access keeps all bits.
    keep_mask = ~({DATA_WIDTH{1'b1}} << access_bits(size_i));
    // Topmost kept bit is the sign bit of the access.
    msb_mask  = keep_mask ^ (keep_mask >> 1);
    sign_bit  = |(shifted & msb_mask);
    data_o    = shifted & keep_mask;
    if (sign_ext_i && sign_bit) data_o = data_o | ~keep_mask;
  end
endmodule

// File: rtl/frost32_mem_access_unit.sv
// Frost32 load/store unit: accepts one CPU request at a time, drives a
// DATA_WIDTH-wide memory port with byte enables and lane-steered data,
// extends load data, flags misaligned/oversized requests and aborts
// accesses stalled longer than TIMEOUT_CYCLES (0 disables the timeout).
//   clk, rst : clock, asynchronous active-high reset
//   bus_if   : CPU request/response and memory bus (slave modport)
module frost32_mem_access_unit
  import frost32_mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  frost32_mem_access_unit_if.slave       bus_if
);
  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BE_W);
  localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0]       MAX_SIZE  = 2'(LANE_BITS);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BE_W - 1);

  typedef struct packed {
    data_inout_access_type_e req_type;
    logic [1:0]              size;
    logic                    sign_ext;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } mem_resp_t;

  mem_access_unit_state_e state_q, state_d;
  mem_req_t               req_q, req_d;
  mem_resp_t              resp_q, resp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   misaligned, oversized, timeout_hit;
  logic [LANE_BITS-1:0]   lane;
  logic [DATA_WIDTH-1:0]  keep_mask, load_data;

  assign lane = req_q.addr[LANE_BITS-1:0];

  // Naturally aligned means the low size bits of the address are zero.
  assign misaligned  = |(bus_if.cpu_req_addr[2:0] & ~(3'b111 << bus_if.cpu_req_size));
  assign oversized   = bus_if.cpu_req_size > MAX_SIZE;
  // Fires on the TIMEOUT_CYCLES-th stalled cycle; a non-stalled cycle never times out.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && bus_if.mem_wait && (cnt_q == CNT_LIMIT);

  frost32_lane_extract #(.DATA_WIDTH(DATA_WIDTH)) u_lane_extract (
    .data_i     (bus_if.mem_rdata),
    .lane_i     (lane),
    .size_i     (req_q.size),
    .sign_ext_i (req_q.sign_ext),
    .data_o     (load_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the request fields are reset too so no X reaches the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch;
  // resp_d defaulting to 0 is what holds the response fields at 0 outside StResp.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = '0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_if.cpu_req_valid) begin
          req_d.req_type = data_inout_access_type_e'(bus_if.cpu_req_type);
          req_d.size     = bus_if.cpu_req_size;
          req_d.sign_ext = bus_if.cpu_req_sign_ext;
          req_d.addr     = bus_if.cpu_req_addr;
          req_d.wdata    = bus_if.cpu_req_wdata;
          if (misaligned || oversized) begin
            state_d    = StResp;
            resp_d.err = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = '0;
          end
        end
      end
      StBusy: begin
        if (!bus_if.mem_wait) begin
          state_d      = StResp;
          resp_d.rdata = (req_q.req_type == DiatRead) ? load_data : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            state_d    = StResp;
            resp_d.err = 1'b1;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory outputs decode straight from the registered state and request, so
  // they are stable through a stall and drop with an asynchronous reset.
  always_comb begin
    keep_mask          = ~({DATA_WIDTH{1'b1}} << access_bits(req_q.size));
    bus_if.mem_req     = 1'b0;
    bus_if.mem_we      = 1'b0;
    bus_if.mem_addr    = '0;
    bus_if.mem_byte_en = '0;
    bus_if.mem_wdata   = '0;
    if (state_q == StBusy) begin
      bus_if.mem_req     = 1'b1;
      bus_if.mem_we      = (req_q.req_type == DiatWrite);
      bus_if.mem_addr    = req_q.addr & ~LANE_MASK;
      bus_if.mem_byte_en = ~({BE_W{1'b1}} << (4'd1 << req_q.size)) << lane;
      bus_if.mem_wdata   = (req_q.wdata & keep_mask) << {lane, 3'b000};
    end
  end

  assign bus_if.cpu_req_ready  = (state_q == StIdle);
  assign bus_if.cpu_resp_valid = (state_q == StResp);
  assign bus_if.cpu_resp_rdata = resp_q.rdata;
  assign bus_if.cpu_resp_err   = resp_q.err;

endmodule

// File: tb/tb_frost32_mem_access_unit.sv
// Self-checking bench: a 32-bit unit (timeout 4) and a 64-bit unit (timeout 8)
// checked every cycle against a transaction-level model of the unit.
module tb_frost32_mem_access_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frost32_mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if32 ();
  frost32_mem_access_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) if64 ();

  frost32_mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut32 (
    .clk(clk), .rst(rst), .bus_if(if32));
  frost32_mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) u_dut64 (
    .clk(clk), .rst(rst), .bus_if(if64));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the transaction in flight, per unit (0 = 32-bit, 1 = 64-bit).
  bit          act [2];
  int          acc [2];   // edge at which the request is accepted
  bit          m_bad [2];
  int          m_b [2];   // memory cycles (mem_req high) before the response
  int          m_w [2];   // stall cycles the memory inserts
  logic [63:0] m_be [2], m_addr [2], m_wdata [2], m_rdata [2], m_rmem [2];
  bit          m_we [2], m_err [2];
  // Observations for directed literal checks.
  logic [63:0] o_be [2], o_addr [2], o_wdata [2], o_rdata [2];
  bit          o_we [2], o_err [2], o_done [2];
  int          o_lat [2], o_req_cnt [2];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic ready_of(input int d);
    return (d == 0) ? if32.cpu_req_ready : if64.cpu_req_ready;
  endfunction

  // Per-cycle compare against the model, plus the memory responder.
  always @(negedge clk) begin : compare
    logic [63:0] a_be, a_addr, a_wd, a_rd;
    logic        a_req, a_we, a_rdy, a_rv, a_err;
    int          k, rk;
    bit          e_req, e_rv, e_rdy, wt;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        a_be = 64'(if32.mem_byte_en); a_addr = 64'(if32.mem_addr); a_wd = 64'(if32.mem_wdata);
        a_rd = 64'(if32.cpu_resp_rdata); a_req = if32.mem_req; a_we = if32.mem_we;
        a_rdy = if32.cpu_req_ready; a_rv = if32.cpu_resp_valid; a_err = if32.cpu_resp_err;
      end else begin
        a_be = 64'(if64.mem_byte_en); a_addr = 64'(if64.mem_addr); a_wd = if64.mem_wdata;
        a_rd = if64.cpu_resp_rdata; a_req = if64.mem_req; a_we = if64.mem_we;
        a_rdy = if64.cpu_req_ready; a_rv = if64.cpu_resp_valid; a_err = if64.cpu_resp_err;
      end
      k     = cyc - acc[d];
      rk    = m_bad[d] ? 0 : m_b[d];
      e_req = act[d] && !m_bad[d] && k >= 0 && k < m_b[d];
      e_rv  = act[d] && k == rk;
      e_rdy = !(act[d] && k >= 0 && k <= rk);
      check("mem_req", a_req, e_req);
      check("cpu_req_ready", a_rdy, e_rdy);
      check("cpu_resp_valid", a_rv, e_rv);
      check("mem_we", a_we, e_req ? m_we[d] : 1'b0);
      check("mem_addr", a_addr, e_req ? m_addr[d] : 64'd0);
      check("mem_byte_en", a_be, e_req ? m_be[d] : 64'd0);
      check("mem_wdata", a_wd, e_req ? m_wdata[d] : 64'd0);
      check("cpu_resp_rdata", a_rd, e_rv ? m_rdata[d] : 64'd0);
      check("cpu_resp_err", a_err, e_rv ? m_err[d] : 1'b0);
      if (act[d] && a_req) begin
        if (o_req_cnt[d] == 0) begin
          o_be[d] = a_be; o_addr[d] = a_addr; o_wdata[d] = a_wd; o_we[d] = a_we;
        end
        o_req_cnt[d]++;
      end
      if (act[d] && a_rv) begin
        o_done[d] = 1'b1; o_lat[d] = k; o_rdata[d] = a_rd; o_err[d] = a_err;
      end
      wt = act[d] && !m_bad[d] && k >= 0 && k < m_w[d];
      if (act[d] && k >= rk) act[d] = 1'b0;
      if (d == 0) begin
        if32.mem_wait  = wt;
        if32.mem_rdata = wt ? 32'($urandom) : m_rmem[0][31:0];
      end else begin
        if64.mem_wait  = wt;
        if64.mem_rdata = wt ? {32'($urandom), 32'($urandom)} : m_rmem[1];
      end
    end
  end

  // Issue one request to unit d, build its expected outcome from the access
  // rules, and wait for the response (or reset the unit mid-access if abort).
  task automatic run(input int d, input bit typ, input logic [1:0] size, input bit sgn,
                     input logic [31:0] addr, input logic [63:0] wdata, input int w,
                     input logic [63:0] rmem, input bit abort = 1'b0);
    int t, dw, tmo, nb, bytes, lane;
    logic [63:0] mask, dmask, v;
    dw = (d == 0) ? 32 : 64;
    tmo = (d == 0) ? 4 : 8;
    nb = dw / 8;
    bytes = 1 << size;
    lane = int'(addr % nb);
    t = 0;
    @(negedge clk);
    while (!ready_of(d) && t < 64) begin @(negedge clk); t++; end
    check("ready_wait", ready_of(d), 1'b1);
    mask  = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
    dmask = (dw == 64) ? '1 : 64'hFFFF_FFFF;
    m_bad[d]   = (bytes > nb) || (addr % bytes != 0);
    m_be[d]    = ((64'd1 << bytes) - 64'd1) << lane;
    m_addr[d]  = 64'(addr) - 64'(lane);
    m_wdata[d] = ((wdata & mask) << (8 * lane)) & dmask;
    m_we[d]    = typ;
    if (m_bad[d]) begin
      m_b[d] = 0; m_err[d] = 1'b1; m_rdata[d] = '0;
    end else if (w >= tmo) begin
      m_b[d] = tmo; m_err[d] = 1'b1; m_rdata[d] = '0;
    end else begin
      m_b[d] = w + 1; m_err[d] = 1'b0;
      if (typ) m_rdata[d] = '0;
      else begin
        v = (rmem >> (8 * lane)) & mask;
        if (sgn && v[8 * bytes - 1]) v = v | ~mask;
        m_rdata[d] = v & dmask;
      end
    end
    m_w[d] = w; m_rmem[d] = rmem;
    o_done[d] = 1'b0; o_req_cnt[d] = 0;
    acc[d] = cyc + 1; act[d] = 1'b1;
    if (d == 0) begin
      if32.cpu_req_valid = 1'b1; if32.cpu_req_type = typ; if32.cpu_req_size = size;
      if32.cpu_req_sign_ext = sgn; if32.cpu_req_addr = addr; if32.cpu_req_wdata = wdata[31:0];
    end else begin
      if64.cpu_req_valid = 1'b1; if64.cpu_req_type = typ; if64.cpu_req_size = size;
      if64.cpu_req_sign_ext = sgn; if64.cpu_req_addr = addr; if64.cpu_req_wdata = wdata;
    end
    @(negedge clk);
    // Scramble the request lines so a unit that fails to latch shows up.
    if32.cpu_req_valid = 1'b0; if32.cpu_req_addr = $urandom; if32.cpu_req_wdata = $urandom;
    if64.cpu_req_valid = 1'b0; if64.cpu_req_addr = $urandom; if64.cpu_req_wdata = {$urandom, $urandom};
    if (abort) begin
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mem_req_drop", if32.mem_req, 1'b0);
      check("rst_ready", if32.cpu_req_ready, 1'b1);
      check("rst_no_resp", if32.cpu_resp_valid, 1'b0);
      act[0] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
    end else begin
      t = 0;
      while (!o_done[d] && t < 64) begin @(negedge clk); t++; end
      check("resp_seen", o_done[d], 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if32.cpu_req_valid = 1'b0; if32.cpu_req_type = 1'b0; if32.cpu_req_size = 2'd0;
    if32.cpu_req_sign_ext = 1'b0; if32.cpu_req_addr = '0; if32.cpu_req_wdata = '0;
    if32.mem_rdata = '0; if32.mem_wait = 1'b0;
    if64.cpu_req_valid = 1'b0; if64.cpu_req_type = 1'b0; if64.cpu_req_size = 2'd0;
    if64.cpu_req_sign_ext = 1'b0; if64.cpu_req_addr = '0; if64.cpu_req_wdata = '0;
    if64.mem_rdata = '0; if64.mem_wait = 1'b0;
    for (int d = 0; d < 2; d++) begin act[d] = 1'b0; acc[d] = 0; m_rmem[d] = '0; end
    #1;
    check("reset_ready32", if32.cpu_req_ready, 1'b1);
    check("reset_mem_req32", if32.mem_req, 1'b0);
    check("reset_resp_valid32", if32.cpu_resp_valid, 1'b0);
    check("reset_ready64", if64.cpu_req_ready, 1'b1);
    check("reset_mem_req64", if64.mem_req, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // 8-bit signed load at 0x1003.
    run(0, 1'b0, 2'd0, 1'b1, 32'h1003, 64'd0, 0, 64'h8000_0000);
    check("lb_byte_en", o_be[0], 64'h8);
    check("lb_addr", o_addr[0], 64'h1000);
    check("lb_rdata", o_rdata[0], 64'hFFFF_FF80);
    check("lb_latency", 64'(o_lat[0]), 64'd1);
    // 16-bit store with three stall cycles.
    run(0, 1'b1, 2'd1, 1'b0, 32'h2002, 64'hBEEF, 3, 64'h1234_5678);
    check("sh_byte_en", o_be[0], 64'hC);
    check("sh_wdata", o_wdata[0], 64'hBEEF_0000);
    check("sh_we", o_we[0], 1'b1);
    check("sh_req_cycles", 64'(o_req_cnt[0]), 64'd4);
    check("sh_latency", 64'(o_lat[0]), 64'd4);
    check("sh_err", o_err[0], 1'b0);
    // Misaligned and oversized requests.
    run(0, 1'b0, 2'd2, 1'b0, 32'h3001, 64'd0, 0, 64'd0);
    check("mis_err", o_err[0], 1'b1);
    check("mis_latency", 64'(o_lat[0]), 64'd0);
    check("mis_no_mem", 64'(o_req_cnt[0]), 64'd0);
    run(0, 1'b0, 2'd3, 1'b0, 32'h0, 64'd0, 0, 64'd0);
    check("big_err", o_err[0], 1'b1);
    check("big_no_mem", 64'(o_req_cnt[0]), 64'd0);
    // Timeout, then completion on the limit cycle.
    run(0, 1'b0, 2'd2, 1'b0, 32'h40, 64'd0, 10, 64'hCAFE_F00D);
    check("to_err", o_err[0], 1'b1);
    check("to_rdata", o_rdata[0], 64'd0);
    check("to_req_cycles", 64'(o_req_cnt[0]), 64'd4);
    run(0, 1'b0, 2'd2, 1'b0, 32'h44, 64'd0, 3, 64'h1234_5678);
    check("limit_err", o_err[0], 1'b0);
    check("limit_rdata", o_rdata[0], 64'h1234_5678);
    check("limit_latency", 64'(o_lat[0]), 64'd4);
    // 64-bit bus.
    run(1, 1'b0, 2'd3, 1'b0, 32'h8, 64'd0, 0, 64'h0123_4567_89AB_CDEF);
    check("ld64_byte_en", o_be[1], 64'hFF);
    check("ld64_rdata", o_rdata[1], 64'h0123_4567_89AB_CDEF);
    run(1, 1'b0, 2'd2, 1'b0, 32'hC, 64'd0, 0, 64'h9ABC_DEF0_1234_5678);
    check("lw64_rdata", o_rdata[1], 64'h0000_0000_9ABC_DEF0);
    check("lw64_byte_en", o_be[1], 64'hF0);
    check("lw64_addr", o_addr[1], 64'h8);
    // Reset while busy, then a fresh request.
    run(0, 1'b0, 2'd2, 1'b0, 32'h100, 64'd0, 10, 64'd0, 1'b1);
    run(0, 1'b0, 2'd1, 1'b0, 32'h102, 64'd0, 1, 64'h8001_0000);
    check("post_rst_rdata", o_rdata[0], 64'h8001);
    check("post_rst_err", o_err[0], 1'b0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 160; i++) begin
      int d, w;
      logic [1:0] size;
      logic [31:0] addr;
      d = int'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      w = int'($urandom_range(0, 10));
      run(d, 1'($urandom), size, 1'($urandom), addr, {$urandom, $urandom}, w,
          {$urandom, $urandom});
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
